shared_det_arbiter: RTL

SHARED_DET_ARBITER -- requirements
Module: shared_det_arbiter

---
 rtl/shared_det_arbiter_pkg.sv | 10 +
 rtl/shared_det_arbiter_if.sv | 21 ++
 rtl/shared_det_arbiter_rr_pick4.sv | 14 +
 rtl/shared_det_arbiter.sv | 63 ++++++
 4 files changed

// File: rtl/shared_det_arbiter_pkg.sv
// shared_det_arbiter_pkg: FSM state encoding and requester count for the shared detector arbiter
package shared_det_arbiter_pkg;
  localparam int NREQ = 4;
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CLEAR   = 2'b01,
    SERVE   = 2'b10,
    RELEASE = 2'b11
  } state_t;
endpackage

// File: rtl/shared_det_arbiter_if.sv
// shared_det_arbiter_if: requester handshake and shared detector hookup
interface shared_det_arbiter_if;
  import shared_det_arbiter_pkg::*;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] bit_in;
  logic            shared_out;
  logic [NREQ-1:0] gnt;
  logic [1:0]      owner;
  logic            busy;
  logic            shared_in;
  logic            shared_rst;
  logic [NREQ-1:0] det_out;
  modport master (
    output req, bit_in, shared_out,
    input  gnt, owner, busy, shared_in, shared_rst, det_out
  );
  modport slave (
    input  req, bit_in, shared_out,
    output gnt, owner, busy, shared_in, shared_rst, det_out
  );
endinterface

// File: rtl/shared_det_arbiter_rr_pick4.sv
// rr_pick4: first set request searching upward (mod 4) from rr_ptr
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] rr_ptr,
  output logic       found,
  output logic [1:0] idx
);
  logic [3:0] rot;
  logic [1:0] off;
  assign rot   = 4'({req, req} >> rr_ptr);
  assign off   = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign found = |req;
  assign idx   = rr_ptr + off;
endmodule

// File: rtl/shared_det_arbiter.sv
// shared_det_arbiter: round-robin time-sharing of one serial sequence detector among four requesters
module shared_det_arbiter
  import shared_det_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int CW        = 8
) (
  input logic clk,
  input logic rst,
  shared_det_arbiter_if.slave bus
);
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);
  state_t          state;
  logic [1:0]      rr_ptr;
  logic [1:0]      pick;
  logic            found;
  logic [CW-1:0]   cnt;
  logic            done;
  rr_pick4 u_pick (.req(bus.req), .rr_ptr(rr_ptr), .found(found), .idx(pick));
  assign done          = !bus.req[bus.owner] || cnt == LAST;
  assign bus.shared_in = (state == SERVE) && bus.bit_in[bus.owner];
  assign bus.det_out   = (state == SERVE) ? {3'b000, bus.shared_out} << bus.owner : '0;
  // arbitration FSM with registered grant, owner, busy and detector reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      cnt            <= '0;
      bus.owner      <= '0;
      bus.gnt        <= '0;
      bus.busy       <= 1'b0;
      bus.shared_rst <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          bus.shared_rst <= found;
          if (found) begin
            state     <= CLEAR;
            bus.owner <= pick;
            bus.gnt   <= 4'b0001 << pick;
            bus.busy  <= 1'b1;
            cnt       <= '0;
          end
        end
        CLEAR: begin
          state          <= SERVE;
          bus.shared_rst <= 1'b0;
        end
        SERVE: begin
          if (done) begin
            state    <= RELEASE;
            bus.gnt  <= '0;
            bus.busy <= 1'b0;
            rr_ptr   <= bus.owner + 2'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
